test_sequencer: RTL and testbench

TEST_SEQUENCER -- requirements
Module: test_sequencer

---
 rtl/test_sequencer.sv | 141 ++++++++++++++
 tb/tb_test_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sequencer.sv
// test_sequencer: drives a reset/run cycle for a DUT and monitors per-channel
// halt/pass flags until every channel has halted or the run times out.
//
// Ports
//   clk        single clock, all state updates on rising edge
//   rst        asynchronous active-low reset of the sequencer
//   start      run request (accepted in IDLE, DONE, TIMEOUT)
//   abort      cancel current run (accepted in RESET, RUN)
//   halt       per-channel halt indication from the DUT
//   pass       per-channel pass flag, valid with the same-cycle halt bit
//   dut_rst    active-low reset to the DUT, released only in RUN
//   busy       high in RESET and RUN
//   done       high in DONE
//   timeout    high in TIMEOUT
//   halted     sticky per-channel halt record for current/last run
//   pass_mask  pass value captured at each channel's first halt
//   all_pass   high in DONE when every channel passed
//   cycle_cnt  RUN cycles elapsed in current/last run
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | waiting for start, DUT held in reset
// S_RESET   | DUT held in reset for RST_CYCLES cycles
// S_RUN     | DUT running, halts recorded, cycle_cnt advancing
// S_DONE    | every channel halted; results frozen until next start
// S_TIMEOUT | TIMEOUT RUN cycles elapsed; results frozen until start

module test_sequencer #(
  parameter int N_CH       = 1,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_CH-1:0]  halt,
  input  logic [N_CH-1:0]  pass,
  output logic             dut_rst,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [N_CH-1:0]  halted,
  output logic [N_CH-1:0]  pass_mask,
  output logic             all_pass,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int RW = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [RW-1:0]    RST_LOAD = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_RUN, S_DONE, S_TIMEOUT
  } state_t;

  state_t          state, nxt;
  logic [RW-1:0]   rst_left, rst_left_nxt;
  logic [N_CH-1:0] new_halt, halted_upd, pm_upd;
  logic [N_CH-1:0] halted_nxt, pm_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic            all_halted;

  // Channels halting this cycle for the first time latch their pass bit;
  // channels already halted keep the value captured earlier.
  assign new_halt   = halt & ~halted;
  assign halted_upd = halted | halt;
  assign pm_upd     = (pass_mask & ~new_halt) | (pass & new_halt);
  assign all_halted = &halted_upd;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (start && !abort) nxt = S_RESET;
      S_RESET: begin
        if (abort)                nxt = S_IDLE;
        else if (rst_left == '0)  nxt = S_RUN;
      end
      // Abort beats completion; completion beats timeout.
      S_RUN: begin
        if (abort)                   nxt = S_IDLE;
        else if (all_halted)         nxt = S_DONE;
        else if (cycle_cnt == TO_LAST) nxt = S_TIMEOUT;
      end
      S_DONE, S_TIMEOUT: if (start) nxt = S_RESET;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    halted_nxt   = halted;
    pm_nxt       = pass_mask;
    cnt_nxt      = cycle_cnt;
    rst_left_nxt = rst_left;
    if (state == S_RESET && rst_left != '0)
      rst_left_nxt = rst_left - RW'(1);
    if (state == S_RUN) begin
      halted_nxt = halted_upd;
      pm_nxt     = pm_upd;
      // Count only while staying in RUN so the final value names the
      // RUN cycle on which the run ended.
      if (nxt == S_RUN && cycle_cnt != '1)
        cnt_nxt = cycle_cnt + CNT_W'(1);
    end
    if (nxt == S_IDLE || (nxt == S_RESET && state != S_RESET)) begin
      halted_nxt = '0;
      pm_nxt     = '0;
      cnt_nxt    = '0;
    end
    if (nxt == S_RESET && state != S_RESET)
      rst_left_nxt = RST_LOAD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rst_left  <= '0;
      halted    <= '0;
      pass_mask <= '0;
      cycle_cnt <= '0;
      dut_rst   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      all_pass  <= 1'b0;
    end else begin
      state     <= nxt;
      rst_left  <= rst_left_nxt;
      halted    <= halted_nxt;
      pass_mask <= pm_nxt;
      cycle_cnt <= cnt_nxt;
      dut_rst   <= (nxt == S_RUN);
      busy      <= (nxt == S_RESET) || (nxt == S_RUN);
      done      <= (nxt == S_DONE);
      timeout   <= (nxt == S_TIMEOUT);
      all_pass  <= (nxt == S_DONE) && (&pm_nxt);
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
module tb_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // dut_a: single channel, TIMEOUT=50
  logic        start_a = 0, abort_a = 0;
  logic [0:0]  halt_a = '0, pass_a = '0;
  logic        dut_rst_a, busy_a, done_a, timeout_a, all_pass_a;
  logic [0:0]  halted_a, pass_mask_a;
  logic [15:0] cnt_a;

  // dut_b: four channels, RST_CYCLES=2, TIMEOUT=40
  logic        start_b = 0, abort_b = 0;
  logic [3:0]  halt_b = '0, pass_b = '0;
  logic        dut_rst_b, busy_b, done_b, timeout_b, all_pass_b;
  logic [3:0]  halted_b, pass_mask_b;
  logic [15:0] cnt_b;

  // dut_c: single channel, TIMEOUT=30 (completion/timeout coincidence)
  logic        start_c = 0, abort_c = 0;
  logic [0:0]  halt_c = '0, pass_c = '0;
  logic        dut_rst_c, busy_c, done_c, timeout_c, all_pass_c;
  logic [0:0]  halted_c, pass_mask_c;
  logic [15:0] cnt_c;

  test_sequencer #(.N_CH(1), .RST_CYCLES(4), .TIMEOUT(50), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .halt(halt_a), .pass(pass_a),
    .dut_rst(dut_rst_a), .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .halted(halted_a), .pass_mask(pass_mask_a), .all_pass(all_pass_a), .cycle_cnt(cnt_a));

  test_sequencer #(.N_CH(4), .RST_CYCLES(2), .TIMEOUT(40), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .halt(halt_b), .pass(pass_b),
    .dut_rst(dut_rst_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .halted(halted_b), .pass_mask(pass_mask_b), .all_pass(all_pass_b), .cycle_cnt(cnt_b));

  test_sequencer #(.N_CH(1), .RST_CYCLES(4), .TIMEOUT(30), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .halt(halt_c), .pass(pass_c),
    .dut_rst(dut_rst_c), .busy(busy_c), .done(done_c), .timeout(timeout_c),
    .halted(halted_c), .pass_mask(pass_mask_c), .all_pass(all_pass_c), .cycle_cnt(cnt_c));

  typedef struct packed {
    logic        st, ab;
    logic [3:0]  h, p;
    logic        drst, busy, done, tmo, allp;
    logic [3:0]  hd, pm;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic st, ab, input logic [3:0] h, p,
                              input logic drst, bsy, dn, tmo, allp,
                              input logic [3:0] hd, pm, input logic [15:0] cnt);
    vec_t v;
    v.st = st; v.ab = ab; v.h = h; v.p = p;
    v.drst = drst; v.busy = bsy; v.done = dn; v.tmo = tmo; v.allp = allp;
    v.hd = hd; v.pm = pm; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // inputs: st ab h p | expected after edge: drst busy done tmo allp halted pmask cnt
    tbl[0]  = mk(1,0,4'h0,4'h0, 0,1,0,0,0, 4'h0,4'h0,0);
    tbl[1]  = mk(0,0,4'hF,4'hF, 0,1,0,0,0, 4'h0,4'h0,0);
    tbl[2]  = mk(0,0,4'h0,4'h0, 1,1,0,0,0, 4'h0,4'h0,0);
    tbl[3]  = mk(0,0,4'h1,4'h1, 1,1,0,0,0, 4'h1,4'h1,1);
    tbl[4]  = mk(0,0,4'h3,4'h0, 1,1,0,0,0, 4'h3,4'h1,2);
    tbl[5]  = mk(0,0,4'h4,4'h4, 1,1,0,0,0, 4'h7,4'h5,3);
    tbl[6]  = mk(0,0,4'h0,4'hF, 1,1,0,0,0, 4'h7,4'h5,4);
    tbl[7]  = mk(1,0,4'h8,4'h8, 0,0,1,0,0, 4'hF,4'hD,4);
    tbl[8]  = mk(0,1,4'h0,4'h0, 0,0,1,0,0, 4'hF,4'hD,4);
    tbl[9]  = mk(1,0,4'h0,4'h0, 0,1,0,0,0, 4'h0,4'h0,0);
    tbl[10] = mk(0,0,4'h0,4'h0, 0,1,0,0,0, 4'h0,4'h0,0);
    tbl[11] = mk(0,0,4'h0,4'h0, 1,1,0,0,0, 4'h0,4'h0,0);
    tbl[12] = mk(0,0,4'hF,4'hF, 0,0,1,0,1, 4'hF,4'hF,0);
    tbl[13] = mk(1,0,4'h0,4'h0, 0,1,0,0,0, 4'h0,4'h0,0);
    tbl[14] = mk(0,1,4'h0,4'h0, 0,0,0,0,0, 4'h0,4'h0,0);
    tbl[15] = mk(1,1,4'h0,4'h0, 0,0,0,0,0, 4'h0,4'h0,0);
    tbl[16] = mk(1,0,4'h0,4'h0, 0,1,0,0,0, 4'h0,4'h0,0);
    tbl[17] = mk(0,0,4'h0,4'h0, 0,1,0,0,0, 4'h0,4'h0,0);
    tbl[18] = mk(0,0,4'h0,4'h0, 1,1,0,0,0, 4'h0,4'h0,0);
    tbl[19] = mk(0,0,4'h3,4'h2, 1,1,0,0,0, 4'h3,4'h2,1);
    tbl[20] = mk(0,1,4'hF,4'hF, 0,0,0,0,0, 4'h0,4'h0,0);

    // reset state
    #12;
    chk("rst.dut_rst", 32'(dut_rst_a), 0);
    chk("rst.busy",    32'(busy_a), 0);
    chk("rst.done",    32'(done_b), 0);
    chk("rst.halted",  32'(halted_b), 0);
    chk("rst.cnt",     32'(cnt_a), 0);
    @(negedge clk); rst = 1'b1;
    tick(); tick();

    // table-driven run on the four-channel instance
    for (int i = 0; i < 21; i++) begin
      start_b = tbl[i].st; abort_b = tbl[i].ab; halt_b = tbl[i].h; pass_b = tbl[i].p;
      tick();
      chk($sformatf("tbl%0d.dut_rst", i),  32'(dut_rst_b),   32'(tbl[i].drst));
      chk($sformatf("tbl%0d.busy", i),     32'(busy_b),      32'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i),     32'(done_b),      32'(tbl[i].done));
      chk($sformatf("tbl%0d.timeout", i),  32'(timeout_b),   32'(tbl[i].tmo));
      chk($sformatf("tbl%0d.all_pass", i), 32'(all_pass_b),  32'(tbl[i].allp));
      chk($sformatf("tbl%0d.halted", i),   32'(halted_b),    32'(tbl[i].hd));
      chk($sformatf("tbl%0d.pass_mask", i),32'(pass_mask_b), 32'(tbl[i].pm));
      chk($sformatf("tbl%0d.cnt", i),      32'(cnt_b),       32'(tbl[i].cnt));
    end
    start_b = 0; abort_b = 0; halt_b = '0; pass_b = '0;

    // nominal: 4 reset cycles, halt+pass on RUN cycle 20
    start_a = 1; tick(); start_a = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("nom.rst%0d.dut_rst", i), 32'(dut_rst_a), 0);
      chk($sformatf("nom.rst%0d.busy", i),    32'(busy_a), 1);
      tick();
    end
    for (int k = 0; k <= 20; k++) begin
      chk($sformatf("nom.run%0d.dut_rst", k), 32'(dut_rst_a), 1);
      chk($sformatf("nom.run%0d.cnt", k),     32'(cnt_a), 32'(k));
      if (k == 20) begin halt_a = 1'b1; pass_a = 1'b1; end
      tick();
    end
    halt_a = 0; pass_a = 0;
    chk("nom.done",     32'(done_a), 1);
    chk("nom.all_pass", 32'(all_pass_a), 1);
    chk("nom.cnt",      32'(cnt_a), 20);
    chk("nom.dut_rst",  32'(dut_rst_a), 0);

    // back-to-back second run from DONE, failing channel
    start_a = 1; tick(); start_a = 0;
    chk("b2b.cnt_clr",    32'(cnt_a), 0);
    chk("b2b.halted_clr", 32'(halted_a), 0);
    chk("b2b.pm_clr",     32'(pass_mask_a), 0);
    chk("b2b.busy",       32'(busy_a), 1);
    repeat (4) tick();
    tick(); tick();
    halt_a = 1'b1; pass_a = 1'b0; tick(); halt_a = 0;
    chk("b2b.done",     32'(done_a), 1);
    chk("b2b.all_pass", 32'(all_pass_a), 0);
    chk("b2b.cnt",      32'(cnt_a), 2);

    // timeout after exactly 50 RUN cycles
    start_a = 1; tick(); start_a = 0;
    repeat (4) tick();
    for (int k = 0; k < 50; k++) begin
      chk($sformatf("tmo.run%0d.timeout", k), 32'(timeout_a), 0);
      chk($sformatf("tmo.run%0d.cnt", k),     32'(cnt_a), 32'(k));
      tick();
    end
    chk("tmo.timeout", 32'(timeout_a), 1);
    chk("tmo.cnt",     32'(cnt_a), 49);
    chk("tmo.dut_rst", 32'(dut_rst_a), 0);
    chk("tmo.done",    32'(done_a), 0);
    abort_a = 1; halt_a = 1; tick(); abort_a = 0; halt_a = 0;
    chk("tmo.hold",        32'(timeout_a), 1);
    chk("tmo.hold_cnt",    32'(cnt_a), 49);
    chk("tmo.hold_halted", 32'(halted_a), 0);

    // multi-channel: halts at RUN cycles 5,9,9,30 with pass 1,0,1,1
    start_b = 1; tick(); start_b = 0;
    repeat (2) tick();
    for (int k = 0; k <= 30; k++) begin
      chk($sformatf("mc.run%0d.done", k), 32'(done_b), 0);
      halt_b = '0; pass_b = 4'($urandom);
      if (k == 5)  begin halt_b = 4'b0001; pass_b = 4'b0001; end
      if (k == 9)  begin halt_b = 4'b0110; pass_b = 4'b0100; end
      if (k == 30) begin halt_b = 4'b1000; pass_b = 4'b1000; end
      tick();
    end
    halt_b = '0; pass_b = '0;
    chk("mc.done",      32'(done_b), 1);
    chk("mc.halted",    32'(halted_b), 32'hF);
    chk("mc.pass_mask", 32'(pass_mask_b), 32'hD);
    chk("mc.all_pass",  32'(all_pass_b), 0);
    chk("mc.cnt",       32'(cnt_b), 30);

    // completion on the last allowed RUN cycle beats timeout
    start_c = 1; tick(); start_c = 0;
    repeat (4) tick();
    for (int k = 0; k <= 29; k++) begin
      if (k == 29) begin halt_c = 1'b1; pass_c = 1'b1; end
      tick();
    end
    halt_c = 0; pass_c = 0;
    chk("coin.done",    32'(done_c), 1);
    chk("coin.timeout", 32'(timeout_c), 0);
    chk("coin.cnt",     32'(cnt_c), 29);

    // abort at RUN cycle 7
    start_b = 1; tick(); start_b = 0;
    repeat (2) tick();
    for (int k = 0; k < 7; k++) begin
      halt_b = (k == 3) ? 4'b0001 : 4'b0000;
      tick();
    end
    halt_b = '0;
    chk("abt.pre_cnt",    32'(cnt_b), 7);
    chk("abt.pre_halted", 32'(halted_b), 1);
    abort_b = 1; tick(); abort_b = 0;
    chk("abt.busy",    32'(busy_b), 0);
    chk("abt.dut_rst", 32'(dut_rst_b), 0);
    chk("abt.cnt",     32'(cnt_b), 0);
    chk("abt.halted",  32'(halted_b), 0);
    chk("abt.done",    32'(done_b), 0);

    // asynchronous reset at RUN cycle 7 of a new run
    start_a = 1; tick(); start_a = 0;
    repeat (4) tick();
    repeat (7) tick();
    chk("arst.pre_cnt",     32'(cnt_a), 7);
    chk("arst.pre_dut_rst", 32'(dut_rst_a), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst.dut_rst",  32'(dut_rst_a), 0);
    chk("arst.busy",     32'(busy_a), 0);
    chk("arst.cnt",      32'(cnt_a), 0);
    chk("arst.done",     32'(done_a), 0);
    chk("arst.timeout",  32'(timeout_a), 0);
    chk("arst.all_pass", 32'(all_pass_a), 0);
    @(negedge clk); rst = 1'b1;
    tick();
    chk("arst.idle_busy", 32'(busy_a), 0);
    chk("arst.idle_done", 32'(done_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
